// File: rtl/kgp_fetch_pkg.sv
// Shared widths, reset PC and FSM encoding for the KGP_RISC instruction-fetch front end.
package kgp_fetch_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC = 13'd0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DELIVER = 2'd2,
      ST_HALTED  = 2'd3
   } fetch_state_e;

   // Sequential next address; wraps silently at the top of the word space.
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
      return p + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/kgp_fetch_if.sv
// Instruction-memory req/ack bus plus the valid/ready instruction stream toward decode.
interface kgp_fetch_if;
   import kgp_fetch_pkg::*;

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;

   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_ack, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_ack, imem_rdata, instr_ready
   );

endinterface

// File: rtl/kgp_fetch_unit.sv
// Fetch FSM: owns the PC, issues one imem request at a time and buffers a single
// instruction for decode; redirects squash in-flight data, halt drains then stops.
module kgp_fetch_unit
   import kgp_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   kgp_fetch_if.master       bus,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic              halted_q, halted_d;
   logic              squash_q, squash_d;
   logic              halt_pend_q, halt_pend_d;

   logic              halt_eff;
   logic [ADDR_W-1:0] tgt;

   assign halt_eff = halt_pend_q | halt;
   assign tgt      = redirect_valid ? redirect_target : pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         req_q       <= 1'b0;
         addr_q      <= RESET_PC;
         valid_q     <= 1'b0;
         instr_q     <= '0;
         ipc_q       <= '0;
         halted_q    <= 1'b0;
         squash_q    <= 1'b0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         valid_q     <= valid_d;
         instr_q     <= instr_d;
         ipc_q       <= ipc_d;
         halted_q    <= halted_d;
         squash_q    <= squash_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_d       = req_q;
      addr_d      = addr_q;
      valid_d     = valid_q;
      instr_d     = instr_q;
      ipc_d       = ipc_q;
      halted_d    = halted_q;
      squash_d    = squash_q;
      halt_pend_d = halt_pend_q;

      unique case (state_q)
         ST_IDLE: begin
            pc_d = tgt;
            if (halt) begin
               state_d  = ST_HALTED;
               halted_d = 1'b1;
            end else if (start) begin
               state_d = ST_FETCH;
               req_d   = 1'b1;
               addr_d  = tgt;
            end
         end

         ST_FETCH: begin
            halt_pend_d = halt_eff;
            if (!req_q) begin
               // One-cycle gap after a dropped response; relaunch unless draining.
               pc_d = tgt;
               if (halt_eff) begin
                  state_d  = ST_HALTED;
                  halted_d = 1'b1;
               end else begin
                  req_d  = 1'b1;
                  addr_d = tgt;
               end
            end else if (bus.imem_ack) begin
               req_d    = 1'b0;
               squash_d = 1'b0;
               if (squash_q || redirect_valid) begin
                  pc_d = tgt;
                  if (halt_eff) begin
                     state_d  = ST_HALTED;
                     halted_d = 1'b1;
                  end
               end else begin
                  instr_d = bus.imem_rdata;
                  ipc_d   = addr_q;
                  valid_d = 1'b1;
                  pc_d    = pc_inc(pc_q);
                  state_d = ST_DELIVER;
               end
            end else if (redirect_valid) begin
               // Request must stay up until acked, so mark its data for discard.
               pc_d     = redirect_target;
               squash_d = 1'b1;
            end
         end

         ST_DELIVER: begin
            halt_pend_d = halt_eff;
            if (redirect_valid || bus.instr_ready) begin
               valid_d = 1'b0;
               pc_d    = tgt;
               if (halt_eff) begin
                  state_d  = ST_HALTED;
                  halted_d = 1'b1;
               end else begin
                  state_d = ST_FETCH;
                  req_d   = 1'b1;
                  addr_d  = tgt;
               end
            end
         end

         ST_HALTED: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = addr_q;
   assign bus.instr_valid = valid_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = ipc_q;
   assign pc              = pc_q;
   assign halted          = halted_q;

endmodule

// File: tb/tb_kgp_fetch_unit.sv
// Directed bench for kgp_fetch_unit: latency-programmable imem model, expected-PC
// scoreboard popped on each decode handshake, and a req-hold protocol monitor.
module tb_kgp_fetch_unit;
   import kgp_fetch_pkg::*;

   logic              clk;
   logic              rst;
   logic              start;
   logic              halt;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_target;
   logic [ADDR_W-1:0] pc;
   logic              halted;

   kgp_fetch_if bus();

   kgp_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .halt            (halt),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .bus             (bus),
      .pc              (pc),
      .halted          (halted)
   );

   int checks = 0;
   int errors = 0;
   int lat    = 0;
   int cnt    = 0;
   int cyc    = 0;
   logic              pend  = 1'b0;
   logic [ADDR_W-1:0] paddr = '0;
   logic [ADDR_W-1:0] expq[$];
   int                hs_cyc[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return {3'b101, a, ~a, 3'b011};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic start_fetch();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drain(input int budget, input string tag);
      int n = 0;
      while (expq.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, expq.size(), 0);
   endtask

   // Memory responder, protocol monitor and scoreboard share one process so
   // they all see the same ack value at each falling edge.
   always @(negedge clk) begin
      if (rst) begin
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = '0;
         cnt  = 0;
         pend = 1'b0;
      end else begin
         if (bus.imem_req) begin
            if (cnt == lat) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = mem_word(bus.imem_addr);
               cnt = 0;
            end else begin
               bus.imem_ack = 1'b0;
               cnt++;
            end
         end else begin
            bus.imem_ack = 1'b0;
            cnt = 0;
         end

         if (pend) begin
            chk("req_held", bus.imem_req, 1);
            chk("addr_held", bus.imem_addr, paddr);
         end
         pend  = bus.imem_req && !bus.imem_ack;
         paddr = bus.imem_addr;

         if (bus.instr_valid && bus.instr_ready) begin
            hs_cyc.push_back(cyc);
            if (expq.size() == 0) begin
               chk("unexpected_instr_pc", bus.instr_pc, 13'h1abc ^ bus.instr_pc ^ 13'h1abc ^ 13'h1fff);
            end else begin
               chk("instr_pc", bus.instr_pc, expq[0]);
               chk("instr", bus.instr, mem_word(expq[0]));
               void'(expq.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      halt = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = '0;
      bus.instr_ready = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      #1;
      chk("rst_req", bus.imem_req, 0);
      chk("rst_addr", bus.imem_addr, RESET_PC);
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_instr", bus.instr, 0);
      chk("rst_instr_pc", bus.instr_pc, 0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_halted", halted, 0);
      tick();
      rst = 1'b0;

      // Back-to-back sequential fetch with zero-latency ack.
      lat = 0;
      bus.instr_ready = 1'b1;
      hs_cyc.delete();
      for (int i = 0; i < 4; i++) expq.push_back(ADDR_W'(i));
      start_fetch();
      drain(40, "seq_drain");
      bus.instr_ready = 1'b0;
      chk("seq_count", hs_cyc.size(), 4);
      for (int i = 1; i < 4; i++)
         if (i < hs_cyc.size()) chk("seq_spacing", hs_cyc[i] - hs_cyc[i-1], 2);
      do_reset();

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_target = 13'h1FFE;
      tick();
      redirect_valid = 1'b0;
      chk("wrap_preset_pc", pc, 13'h1FFE);
      bus.instr_ready = 1'b1;
      expq.push_back(13'h1FFE);
      expq.push_back(13'h1FFF);
      expq.push_back(13'h0000);
      start_fetch();
      drain(40, "wrap_drain");
      chk("wrap_pc", pc, 13'h0001);
      chk("wrap_addr", bus.imem_addr, 13'h0001);
      bus.instr_ready = 1'b0;
      do_reset();

      // Redirect while a slow request is outstanding: held, dropped, relaunched.
      lat = 3;
      redirect_valid = 1'b1;
      redirect_target = 13'h0005;
      tick();
      redirect_valid = 1'b0;
      bus.instr_ready = 1'b1;
      start_fetch();
      chk("sq_req0", bus.imem_req, 1);
      chk("sq_addr0", bus.imem_addr, 13'h0005);
      redirect_valid = 1'b1;
      redirect_target = 13'h0100;
      tick();
      redirect_valid = 1'b0;
      chk("sq_pc", pc, 13'h0100);
      chk("sq_addr1", bus.imem_addr, 13'h0005);
      tick();
      chk("sq_addr2", bus.imem_addr, 13'h0005);
      tick();
      chk("sq_req3", bus.imem_req, 1);
      chk("sq_addr3", bus.imem_addr, 13'h0005);
      tick();
      chk("sq_gap", bus.imem_req, 0);
      chk("sq_gap_valid", bus.instr_valid, 0);
      tick();
      chk("sq_req_new", bus.imem_req, 1);
      chk("sq_addr_new", bus.imem_addr, 13'h0100);
      expq.push_back(13'h0100);
      drain(40, "sq_drain");
      bus.instr_ready = 1'b0;
      do_reset();

      // Decode backpressure: buffered instruction stays put, no new request.
      lat = 0;
      expq.push_back(13'h0000);
      start_fetch();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", bus.instr_valid, 1);
         chk("bp_instr_pc", bus.instr_pc, 13'h0000);
         chk("bp_instr", bus.instr, mem_word(13'h0000));
         chk("bp_req", bus.imem_req, 0);
         tick();
      end
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      chk("bp_next_req", bus.imem_req, 1);
      chk("bp_next_addr", bus.imem_addr, 13'h0001);
      chk("bp_valid_clr", bus.instr_valid, 0);
      chk("bp_drained", expq.size(), 0);
      do_reset();

      // Halt with a request outstanding: it completes and is delivered, then stop.
      lat = 2;
      redirect_valid = 1'b1;
      redirect_target = 13'h0010;
      tick();
      redirect_valid = 1'b0;
      bus.instr_ready = 1'b1;
      start_fetch();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      expq.push_back(13'h0010);
      drain(40, "halt_drain");
      tick();
      chk("halt_halted", halted, 1);
      chk("halt_req", bus.imem_req, 0);
      chk("halt_valid", bus.instr_valid, 0);
      start = 1'b1;
      redirect_valid = 1'b1;
      redirect_target = 13'h0055;
      tick();
      start = 1'b0;
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("halted_req", bus.imem_req, 0);
      end
      chk("halted_stay", halted, 1);
      chk("halted_pc", pc, 13'h0011);
      bus.instr_ready = 1'b0;
      do_reset();

      // Asynchronous reset in the middle of a fetch.
      lat = 5;
      start_fetch();
      tick();
      chk("ar_req_before", bus.imem_req, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_req", bus.imem_req, 0);
      chk("ar_valid", bus.instr_valid, 0);
      chk("ar_pc", pc, RESET_PC);
      chk("ar_addr", bus.imem_addr, RESET_PC);
      chk("ar_halted", halted, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("ar_idle_req", bus.imem_req, 0);
      start_fetch();
      chk("ar_restart_req", bus.imem_req, 1);
      chk("ar_restart_addr", bus.imem_addr, RESET_PC);
      do_reset();

      chk("final_queue_empty", expq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
